// File: rtl/add_shr_arbiter.sv
// add_shr_arbiter: round-robin owner selection for one shared add unit and one
// shared shr unit. A requester keeps ownership for as long as it holds req.
// The grant is registered. The owner's operands are muxed onto the shared units,
// and the unit results are broadcast back to every requester.
module add_shr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [16*N-1:0] add_a_bus,
    input  logic [16*N-1:0] add_b_bus,
    input  logic [16*N-1:0] shr_a_bus,
    input  logic [16*N-1:0] shr_b_bus,
    output logic [N-1:0]    grant,
    output logic [15:0]     add_a,
    output logic [15:0]     add_b,
    output logic [15:0]     shr_a,
    output logic [15:0]     shr_b,
    input  logic [15:0]     add_in,
    input  logic [15:0]     shr_in,
    output logic [15:0]     add_out,
    output logic [15:0]     shr_out,
    output logic            busy,
    output logic            hold_err
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD + 2);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD + 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N - 1);
    localparam logic [N-1:0]     GRANT_LSB  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // First set request bit scanning base+1, base+2, ... modulo N.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     r,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(base) + k) % N;
            pick  = (!found && r[idx]) ? IDX_W'(idx) : pick;
            found = found | r[idx];
        end
        return pick;
    endfunction

    // Index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic logic [IDX_W-1:0] onehot_index(input logic [N-1:0] g);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | (IDX_W'(i) & {IDX_W{g[i]}});
        end
        return idx;
    endfunction

    state_t           state_r, state_s;
    logic [N-1:0]     grant_r, grant_s;
    logic [IDX_W-1:0] last_r, last_s;
    logic [IDX_W-1:0] owner_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic             hold_err_r, hold_err_s;
    logic             busy_r;
    logic [15:0]      add_a_s, add_b_s, shr_a_s, shr_b_s;

    assign owner_s = onehot_index(grant_r);

    // Next grant / state / last-owner pointer; handoff happens on the release edge.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_s = GRANT_LSB << rr_pick(req, last_r);
                    state_s = ST_OWNED;
                end else begin
                    grant_s = {N{1'b0}};
                    state_s = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (req[owner_s]) begin
                    grant_s = grant_r;
                end else begin
                    last_s = owner_s;
                    // The owner's req is low, so scanning from it naturally skips it.
                    if (|req) begin
                        grant_s = GRANT_LSB << rr_pick(req, owner_s);
                        state_s = ST_OWNED;
                    end else begin
                        grant_s = {N{1'b0}};
                        state_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {N{1'b0}};
            end
        endcase
    end

    // Ownership-length counter: restarts on any grant change and saturates past MAX_HOLD.
    always_comb begin
        hold_cnt_s = hold_cnt_r;
        if (grant_s != grant_r) begin
            hold_cnt_s = {CNT_W{1'b0}};
        end else if ((state_r == ST_OWNED) && (hold_cnt_r != HOLD_LIMIT)) begin
            hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end else begin
            hold_cnt_s = hold_cnt_r;
        end
        hold_err_s = hold_err_r | (hold_cnt_s == HOLD_LIMIT);
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= {N{1'b0}};
            last_r     <= LAST_INIT;
            hold_cnt_r <= {CNT_W{1'b0}};
            hold_err_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
            hold_err_r <= hold_err_s;
            busy_r     <= |grant_s;
        end
    end

    // AND-OR operand mux from the one-hot grant; all zero when nobody owns the units.
    always_comb begin
        add_a_s = 16'd0;
        add_b_s = 16'd0;
        shr_a_s = 16'd0;
        shr_b_s = 16'd0;
        for (int i = 0; i < N; i++) begin
            add_a_s = add_a_s | (add_a_bus[16*i +: 16] & {16{grant_r[i]}});
            add_b_s = add_b_s | (add_b_bus[16*i +: 16] & {16{grant_r[i]}});
            shr_a_s = shr_a_s | (shr_a_bus[16*i +: 16] & {16{grant_r[i]}});
            shr_b_s = shr_b_s | (shr_b_bus[16*i +: 16] & {16{grant_r[i]}});
        end
    end

    assign grant    = grant_r;
    assign busy     = busy_r;
    assign hold_err = hold_err_r;
    assign add_a    = add_a_s;
    assign add_b    = add_b_s;
    assign shr_a    = shr_a_s;
    assign shr_b    = shr_b_s;
    assign add_out  = add_in;
    assign shr_out  = shr_in;

endmodule
